// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register in-flight age/latency tracking,
// load/MUL stall generation and per-operand forward-stage selection.
// Optional SCOREBOARD_PERF_EN adds stall_cycles / stall_hist performance outputs.
module id_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int WB_DEPTH = 3,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 2,
    parameter int SEL_W    = $clog2(WB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_read,
    input  logic              rt_read,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              dst_we,
    input  logic [1:0]        lat_class,
    output logic              stall,
    output logic              issue,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              busy
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [7:0]        stall_hist
`endif
);

    localparam int MAX_LAT    = WB_DEPTH - 1;
    localparam int LOAD_LAT_C = (LOAD_LAT < 1) ? 1 : ((LOAD_LAT > MAX_LAT) ? MAX_LAT : LOAD_LAT);
    localparam int MUL_LAT_C  = (MUL_LAT < 1) ? 1 : ((MUL_LAT > MAX_LAT) ? MAX_LAT : MUL_LAT);

    // Elaboration-time parameter sanity checks
    if (WB_DEPTH < 2) begin : g_bad_depth
        $error("id_scoreboard: WB_DEPTH must be at least 2");
    end
    if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr
        $error("id_scoreboard: ADDR_W too narrow for NUM_REGS");
    end
    if ((LOAD_LAT < 1) || (LOAD_LAT > MAX_LAT)) begin : g_bad_load
        $error("id_scoreboard: LOAD_LAT out of range 1..WB_DEPTH-1");
    end
    if ((MUL_LAT < 1) || (MUL_LAT > MAX_LAT)) begin : g_bad_mul
        $error("id_scoreboard: MUL_LAT out of range 1..WB_DEPTH-1");
    end

    logic [SEL_W-1:0] age     [NUM_REGS];
    logic [SEL_W-1:0] lat     [NUM_REGS];
    logic [SEL_W-1:0] age_nxt [NUM_REGS];
    logic [SEL_W-1:0] lat_nxt [NUM_REGS];
    logic             busy_nxt;

    logic [SEL_W-1:0] rs_age;
    logic [SEL_W-1:0] rs_lat;
    logic [SEL_W-1:0] rt_age;
    logic [SEL_W-1:0] rt_lat;
    logic             rs_haz;
    logic             rt_haz;
    logic             wr_en;
    logic [SEL_W-1:0] cls_lat;

    // Source operand lookup; register 0 is never tracked so it always reads as idle
    always_comb begin
        rs_age = '0;
        rs_lat = '0;
        rt_age = '0;
        rt_lat = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rs_addr == ADDR_W'(r)) begin
                rs_age = age[r];
                rs_lat = lat[r];
            end
            if (rt_addr == ADDR_W'(r)) begin
                rt_age = age[r];
                rt_lat = lat[r];
            end
        end
    end

    always_comb begin
        rs_haz     = rs_read && (rs_age != '0) && (rs_age < rs_lat);
        rt_haz     = rt_read && (rt_age != '0) && (rt_age < rt_lat);
        stall      = id_valid && !flush && !rst && (rs_haz || rt_haz);
        issue      = id_valid && !flush && !rst && !(rs_haz || rt_haz);
        fwd_rs_sel = rs_age;
        fwd_rt_sel = rt_age;
        wr_en      = issue && dst_we && (dst_addr != '0);
    end

    always_comb begin
        case (lat_class)
            2'd1:    cls_lat = SEL_W'(LOAD_LAT_C);
            2'd2:    cls_lat = SEL_W'(MUL_LAT_C);
            default: cls_lat = SEL_W'(1);
        endcase
    end

    // Age every in-flight entry; a fresh issue to the same register restarts it
    always_comb begin
        age_nxt  = age;
        lat_nxt  = lat;
        busy_nxt = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (wr_en && (dst_addr == ADDR_W'(r))) begin
                age_nxt[r] = SEL_W'(1);
                lat_nxt[r] = cls_lat;
            end else if (age[r] != '0) begin
                if ((int'(age[r]) + 1) >= WB_DEPTH) begin
                    age_nxt[r] = '0;
                end else begin
                    age_nxt[r] = age[r] + SEL_W'(1);
                end
            end
            if (age_nxt[r] != '0) begin
                busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age  <= '{default: '0};
            lat  <= '{default: '0};
            busy <= 1'b0;
        end else begin
            age  <= age_nxt;
            lat  <= lat_nxt;
            busy <= busy_nxt;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    // Stall counter (wrapping) and recent-stall history, newest in bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            stall_hist   <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            stall_hist <= {stall_hist[6:0], stall};
        end
    end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: two configurations driven in parallel, checked every
// cycle against a timestamp-based issue-history model plus literal expectations.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, flush, rs_read, rt_read, dst_we;
    logic [4:0] rs_addr, rt_addr, dst_addr;
    logic [1:0] lat_class;

    logic       stall_a, issue_a, busy_a, stall_b, issue_b, busy_b;
    logic [1:0] rs_sel_a, rt_sel_a, rs_sel_b, rt_sel_b;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] sc_a, sc_b;
    logic [7:0]  sh_a, sh_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: default config (WB_DEPTH=3, LOAD_LAT=2, MUL_LAT=2)
    id_scoreboard dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_read(rs_read), .rt_read(rt_read),
        .dst_addr(dst_addr), .dst_we(dst_we), .lat_class(lat_class),
        .stall(stall_a), .issue(issue_a), .fwd_rs_sel(rs_sel_a), .fwd_rt_sel(rt_sel_a),
        .busy(busy_a)
`ifdef SCOREBOARD_PERF_EN
        , .stall_cycles(sc_a), .stall_hist(sh_a)
`endif
    );

    // Instance 1: deeper pipe (WB_DEPTH=4, LOAD_LAT=3, MUL_LAT=2)
    id_scoreboard #(.WB_DEPTH(4), .LOAD_LAT(3), .MUL_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_read(rs_read), .rt_read(rt_read),
        .dst_addr(dst_addr), .dst_we(dst_we), .lat_class(lat_class),
        .stall(stall_b), .issue(issue_b), .fwd_rs_sel(rs_sel_b), .fwd_rt_sel(rt_sel_b),
        .busy(busy_b)
`ifdef SCOREBOARD_PERF_EN
        , .stall_cycles(sc_b), .stall_hist(sh_b)
`endif
    );

    // Model: remember the cycle each register was last issued to and its latency
    int       t_iss [2][32];
    int       lat_m [2][32];
    int       cyc = 0;
    int       m_cnt [2];
    bit [7:0] m_hist [2];
    bit       started = 1'b0;

    function automatic int depth(int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int lat_of(int i, int cls);
        if (cls == 1) return (i == 0) ? 2 : 3;
        if (cls == 2) return 2;
        return 1;
    endfunction

    function automatic int m_age(int i, int r);
        int a;
        if (r == 0 || t_iss[i][r] < 0) return 0;
        a = cyc - t_iss[i][r];
        return (a < depth(i)) ? a : 0;
    endfunction

    function automatic bit m_haz(int i, bit rd, int r);
        return rd && (m_age(i, r) != 0) && (m_age(i, r) < lat_m[i][r]);
    endfunction

    function automatic bit m_stall(int i);
        return id_valid && !flush &&
               (m_haz(i, rs_read, int'(rs_addr)) || m_haz(i, rt_read, int'(rt_addr)));
    endfunction

    function automatic bit m_issue(int i);
        return id_valid && !flush && !m_stall(i);
    endfunction

    function automatic bit m_busy(int i);
        for (int r = 1; r < 32; r++) if (m_age(i, r) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    t_iss[i][r] = -1;
                    lat_m[i][r] = 0;
                end
                m_cnt[i]  = 0;
                m_hist[i] = 8'h00;
            end else begin
                bit st, is;
                st = m_stall(i);
                is = m_issue(i);
                m_cnt[i]  = m_cnt[i] + int'(st);
                m_hist[i] = {m_hist[i][6:0], st};
                if (is && dst_we && dst_addr != 5'd0) begin
                    t_iss[i][dst_addr] = cyc;
                    lat_m[i][dst_addr] = lat_of(i, int'(lat_class));
                end
            end
        end
        cyc++;
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    chk($sformatf("stall[%0d]", i), int'(i == 0 ? stall_a : stall_b), int'(m_stall(i)));
                    chk($sformatf("issue[%0d]", i), int'(i == 0 ? issue_a : issue_b), int'(m_issue(i)));
                end
                chk($sformatf("fwd_rs_sel[%0d]", i), int'(i == 0 ? rs_sel_a : rs_sel_b), m_age(i, int'(rs_addr)));
                chk($sformatf("fwd_rt_sel[%0d]", i), int'(i == 0 ? rt_sel_a : rt_sel_b), m_age(i, int'(rt_addr)));
                chk($sformatf("busy[%0d]", i), int'(i == 0 ? busy_a : busy_b), int'(m_busy(i)));
`ifdef SCOREBOARD_PERF_EN
                chk($sformatf("stall_cycles[%0d]", i), int'(i == 0 ? sc_a : sc_b), m_cnt[i]);
                chk($sformatf("stall_hist[%0d]", i), int'(i == 0 ? sh_a : sh_b), int'(m_hist[i]));
`endif
            end
        end
    end

    task automatic op(bit r, bit v, int rs, bit rsr, int rt, bit rtr, int d, bit we, int cls, bit fl);
        @(posedge clk);
        #1;
        rst       = r;
        id_valid  = v;
        rs_addr   = 5'(rs);
        rs_read   = rsr;
        rt_addr   = 5'(rt);
        rt_read   = rtr;
        dst_addr  = 5'(d);
        dst_we    = we;
        lat_class = 2'(cls);
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic alu(int d, int rs, int rt);
        op(0, 1, rs, 1, rt, 1, d, 1, 0, 0);
    endtask
    task automatic ld(int d);
        op(0, 1, 1, 1, 0, 0, d, 1, 1, 0);
    endtask
    task automatic rd(int rs, int rt);
        op(0, 1, rs, 1, rt, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; rs_read = 1'b0; rt_read = 1'b0;
        dst_we = 1'b0; rs_addr = '0; rt_addr = '0; dst_addr = '0; lat_class = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;

        // Reset state; an instruction presented during reset is not recorded
        op(1, 1, 1, 1, 0, 0, 9, 1, 1, 0);
        idle(1);
        chk("reset_busy_a", int'(busy_a), 0);
        chk("reset_busy_b", int'(busy_b), 0);
        rd(9, 0);
        chk("reset_rd9_stall", int'(stall_a), 0);
        chk("reset_rd9_sel", int'(rs_sel_a), 0);

        // ALU back-to-back chain forwards from EX, then MEM, then regfile
        alu(3, 1, 2);
        chk("alu3_issue", int'(issue_a), 1);
        alu(4, 3, 3);
        chk("alu_chain_stall", int'(stall_a), 0);
        chk("alu_chain_rs", int'(rs_sel_a), 1);
        chk("alu_chain_rt", int'(rt_sel_a), 1);
        rd(3, 0);
        chk("alu_plus1_sel", int'(rs_sel_a), 2);
        rd(3, 0);
        chk("alu_plus2_sel_a", int'(rs_sel_a), 0);
        chk("alu_plus2_sel_b", int'(rs_sel_b), 3);
        idle(3);

        // Load-use: one stall then forward from MEM (deeper config stalls longer)
        ld(5);
        chk("lw5_issue", int'(issue_a), 1);
        op(0, 1, 5, 1, 0, 1, 6, 1, 0, 0);
        chk("lu_stall_a", int'(stall_a), 1);
        chk("lu_issue_a", int'(issue_a), 0);
        chk("lu_stall_b", int'(stall_b), 1);
        op(0, 1, 5, 1, 0, 1, 6, 1, 0, 0);
        chk("lu2_stall_a", int'(stall_a), 0);
        chk("lu2_issue_a", int'(issue_a), 1);
        chk("lu2_sel_a", int'(rs_sel_a), 2);
        chk("lu2_stall_b", int'(stall_b), 1);
        idle(4);

        // MUL dependency, deep pipe sees stage 3 then retirement
        op(0, 1, 1, 1, 2, 1, 7, 1, 2, 0);
        rd(7, 0);
        chk("mul_stall_a", int'(stall_a), 1);
        chk("mul_stall_b", int'(stall_b), 1);
        rd(7, 0);
        chk("mul_go_stall_b", int'(stall_b), 0);
        chk("mul_go_sel_b", int'(rs_sel_b), 2);
        rd(7, 0);
        chk("mul_plus3_sel_b", int'(rs_sel_b), 3);
        chk("mul_plus3_sel_a", int'(rs_sel_a), 0);
        rd(7, 0);
        chk("mul_plus4_sel_b", int'(rs_sel_b), 0);
        chk("mul_plus4_busy_b", int'(busy_b), 0);

        // Register 0 is never tracked
        ld(0);
        rd(0, 0);
        chk("r0_stall", int'(stall_a), 0);
        chk("r0_sel", int'(rs_sel_a), 0);
        chk("r0_busy_a", int'(busy_a), 0);
        chk("r0_busy_b", int'(busy_b), 0);

        // Flushed consumer: no stall, no issue, destination not recorded
        ld(10);
        op(0, 1, 10, 1, 0, 1, 11, 1, 0, 1);
        chk("flush_stall", int'(stall_a), 0);
        chk("flush_issue", int'(issue_a), 0);
        idle(1);
        rd(11, 0);
        chk("flush_r11_sel_a", int'(rs_sel_a), 0);
        chk("flush_r11_sel_b", int'(rs_sel_b), 0);

        // WAW: ALU write to a load's destination restarts it with ALU latency
        ld(12);
        alu(12, 1, 0);
        chk("waw_issue", int'(issue_a), 1);
        rd(12, 0);
        chk("waw_stall_a", int'(stall_a), 0);
        chk("waw_sel_a", int'(rs_sel_a), 1);
        chk("waw_stall_b", int'(stall_b), 0);

        // Unread source never stalls but select still reports the stage
        ld(16);
        op(0, 1, 16, 0, 0, 0, 17, 1, 0, 0);
        chk("noread_stall", int'(stall_a), 0);
        chk("noread_sel", int'(rs_sel_a), 1);
        idle(4);

        // Reset mid-flight discards tracking
        ld(8);
        op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd(8, 0);
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_stall", int'(stall_a), 0);
        chk("rst_mid_sel", int'(rs_sel_a), 0);

        // Three load-use pairs
        for (int k = 13; k <= 15; k++) begin
            ld(k);
            op(0, 1, k, 1, 0, 1, 20, 1, 0, 0);
            op(0, 1, k, 1, 0, 1, 20, 1, 0, 0);
        end
        idle(1);
`ifdef SCOREBOARD_PERF_EN
        chk("perf_cycles", int'(sc_a), 3);
        chk("perf_hist", int'(sh_a), 'h92);
`endif
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
